// File: rtl/booth_ctrl_fsm.sv
// ============================================================================
// Module   : booth_ctrl_fsm
// Purpose  : Control sequencer for the radix-2 Booth multiplier. It drives the
//            datapath strobes and the iteration counter, and reports busy/done.
// Option   : BOOTH_CTRL_START_ERR_EN adds a sticky 'err' output for start
//            requests that arrive while an operation is in progress.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module booth_ctrl_fsm #(
   parameter int N_BITS      = 16,
   parameter int COUNT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   q0,
   input  logic                   q_1,
   input  logic [COUNT_WIDTH-1:0] count_in,
   output logic                   count_en,
   output logic                   decr,
   output logic                   load_m,
   output logic                   load_q,
   output logic                   clr_a,
   output logic                   clr_q_1,
   output logic                   add_sub_en,
   output logic                   sub,
   output logic                   shift,
   output logic                   busy,
`ifdef BOOTH_CTRL_START_ERR_EN
   output logic                   err,
`endif
   output logic                   done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_ADD   = 3'd3,
      S_SUB   = 3'd4,
      S_SHIFT = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] c_max_count = COUNT_WIDTH'(N_BITS);
   localparam logic [COUNT_WIDTH-1:0] c_last_iter = COUNT_WIDTH'(1);

   state_t r_state;
   state_t w_next;
   logic   w_count_bad;

   // An exhausted or out-of-range counter in CHECK exits rather than loop.
   assign w_count_bad = (count_in == '0) || (count_in > c_max_count);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE  : if (start) w_next = S_LOAD;
         S_LOAD  : w_next = S_CHECK;
         S_CHECK : begin
            if (w_count_bad)               w_next = S_DONE;
            else if ({q0, q_1} == 2'b10)   w_next = S_SUB;
            else if ({q0, q_1} == 2'b01)   w_next = S_ADD;
            else                           w_next = S_SHIFT;
         end
         S_ADD, S_SUB : w_next = S_SHIFT;
         S_SHIFT : w_next = (count_in == c_last_iter) ? S_DONE : S_CHECK;
         S_DONE  : w_next = S_IDLE;
         default : w_next = S_IDLE;
      endcase
   end

   // Moore decode: outputs depend on the state register alone.
   always_comb begin
      count_en   = 1'b0;
      decr       = 1'b0;
      load_m     = 1'b0;
      load_q     = 1'b0;
      clr_a      = 1'b0;
      clr_q_1    = 1'b0;
      add_sub_en = 1'b0;
      sub        = 1'b0;
      shift      = 1'b0;
      done       = 1'b0;
      busy       = (r_state != S_IDLE);
      case (r_state)
         S_LOAD : begin
            load_m   = 1'b1;
            load_q   = 1'b1;
            clr_a    = 1'b1;
            clr_q_1  = 1'b1;
            count_en = 1'b1;
         end
         S_ADD  : add_sub_en = 1'b1;
         S_SUB  : begin
            add_sub_en = 1'b1;
            sub        = 1'b1;
         end
         S_SHIFT : begin
            shift = 1'b1;
            decr  = 1'b1;
         end
         S_DONE  : done = 1'b1;
         default : ;
      endcase
   end

`ifdef BOOTH_CTRL_START_ERR_EN
   logic r_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err <= 1'b0;
      end else if (start && (r_state == S_IDLE)) begin
         r_err <= 1'b0;
      end else if (start && (r_state != S_DONE)) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_booth_ctrl_fsm.sv
// Testbench for booth_ctrl_fsm: a behavioural Booth datapath and counter close
// the loop, and each run is checked against arithmetic expectations.
`timescale 1ns/1ps
`default_nettype none

module tb_booth_ctrl_fsm;

   localparam int COUNT_WIDTH = 5;

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic                   start = 1'b0;
   logic                   q0;
   logic                   q_1;
   logic [COUNT_WIDTH-1:0] count_in;
   logic count_en, decr, load_m, load_q, clr_a, clr_q_1;
   logic add_sub_en, sub, shift, busy, done;
`ifdef BOOTH_CTRL_START_ERR_EN
   logic err;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   booth_ctrl_fsm #(.N_BITS(16), .COUNT_WIDTH(COUNT_WIDTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .q0         (q0),
      .q_1        (q_1),
      .count_in   (count_in),
      .count_en   (count_en),
      .decr       (decr),
      .load_m     (load_m),
      .load_q     (load_q),
      .clr_a      (clr_a),
      .clr_q_1    (clr_q_1),
      .add_sub_en (add_sub_en),
      .sub        (sub),
      .shift      (shift),
      .busy       (busy),
`ifdef BOOTH_CTRL_START_ERR_EN
      .err        (err),
`endif
      .done       (done)
   );

   always #5 clk = ~clk;

   // Behavioural datapath and iteration counter driven by the DUT strobes.
   logic [15:0]        mcand  = '0;
   logic [15:0]        mplier = '0;
   logic signed [16:0] r_a    = '0;
   logic signed [16:0] r_m    = '0;
   logic [15:0]        r_q    = '0;
   logic               r_q_1  = 1'b0;
   logic [4:0]         r_cnt  = '0;

   always @(posedge clk) begin
      if (load_m)  r_m   <= {mcand[15], mcand};
      if (load_q)  r_q   <= mplier;
      if (clr_a)   r_a   <= '0;
      if (clr_q_1) r_q_1 <= 1'b0;
      if (add_sub_en) r_a <= sub ? (r_a - r_m) : (r_a + r_m);
      if (shift) {r_a, r_q, r_q_1} <= {r_a[16], r_a, r_q};
      if (count_en)  r_cnt <= 5'd16;
      else if (decr) r_cnt <= r_cnt - 5'd1;
   end

   assign q0       = r_q[0];
   assign q_1      = r_q_1;
   assign count_in = r_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {21'd0, count_en, decr, load_m, load_q, clr_a, clr_q_1,
              add_sub_en, sub, shift, busy, done};
   endfunction

   // One multiply: poke pulses start during the first CHECK, hold keeps start
   // high throughout so it must be re-accepted only after the idle cycle.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input bit poke, input bit hold);
      int   exp_add = 0, exp_sub = 0;
      int   n_add = 0, n_sub = 0, n_shift = 0, n_cen = 0, n_decr = 0;
      int   c_done = 0, busy_bad = 0, sa, sb;
      logic prev = 1'b0;
      logic err_seen = 1'b0;
      logic [31:0] exp_p, got_p;
      for (int i = 0; i < 16; i++) begin
         if (b[i] && !prev)      exp_sub++;
         else if (!b[i] && prev) exp_add++;
         prev = b[i];
      end
      sa    = $signed(a);
      sb    = $signed(b);
      exp_p = 32'(sa * sb);

      @(negedge clk);
      mcand = a; mplier = b; start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (!hold) start = poke && (c == 2);
         n_cen   += int'(count_en);
         n_shift += int'(shift);
         n_decr  += int'(decr);
         if (add_sub_en &&  sub) n_sub++;
         if (add_sub_en && !sub) n_add++;
         if (!busy) busy_bad++;
`ifdef BOOTH_CTRL_START_ERR_EN
         err_seen = err;
`endif
         if (done) begin
            c_done = c;
            break;
         end
      end
      got_p = {r_a[15:0], r_q};
      chk("done_latency", 32'(c_done), 32'(34 + exp_add + exp_sub));
      chk("product",      got_p, exp_p);
      chk("shift_pulses", 32'(n_shift), 32'd16);
      chk("decr_pulses",  32'(n_decr),  32'd16);
      chk("count_en_pulses", 32'(n_cen), 32'd1);
      chk("add_visits",   32'(n_add), 32'(exp_add));
      chk("sub_visits",   32'(n_sub), 32'(exp_sub));
      chk("busy_gap",     32'(busy_bad), 32'd0);
`ifdef BOOTH_CTRL_START_ERR_EN
      chk("err_sticky",   32'(err_seen), 32'(poke | hold));
`else
      chk("err_absent",   32'(err_seen), 32'd0);
`endif
      @(negedge clk);
      chk("idle_after_done", {30'd0, busy, done}, 32'd0);
      if (hold) begin
         @(negedge clk);
         chk("reaccept_after_idle", {30'd0, busy, count_en}, 32'd3);
`ifdef BOOTH_CTRL_START_ERR_EN
         chk("err_cleared_on_start", 32'(err), 32'd0);
`endif
         start = 1'b0;
         for (int c = 0; c < 80 && !done; c++) @(negedge clk);
         chk("drain_done", 32'(done), 32'd1);
         @(negedge clk);
      end
   endtask

   initial begin
      int n_sh;
      repeat (2) @(negedge clk);
      chk("reset_outputs", all_outs(), 32'd0);
`ifdef BOOTH_CTRL_START_ERR_EN
      chk("reset_err", 32'(err), 32'd0);
`endif
      reset_n = 1'b1;
      @(negedge clk);

      run_op(16'($urandom), 16'h0000, 1'b0, 1'b0);
      run_op(16'($urandom), 16'h0001, 1'b0, 1'b0);
      run_op(16'($urandom), 16'hFFFF, 1'b0, 1'b0);
      run_op(16'h8000,      16'h8000, 1'b0, 1'b0);
      run_op(16'($urandom), 16'h5555, 1'b1, 1'b0);
      run_op(16'($urandom), 16'($urandom), 1'b0, 1'b0);
      run_op(16'($urandom), 16'($urandom), 1'b0, 1'b1);

      // Abort during the 7th SHIFT, then a fresh full run.
      @(negedge clk);
      mcand = 16'($urandom); mplier = 16'($urandom); start = 1'b1;
      @(posedge clk);
      n_sh = 0;
      for (int c = 1; c <= 80 && n_sh < 7; c++) begin
         @(negedge clk);
         start = 1'b0;
         n_sh += int'(shift);
      end
      chk("reached_7th_shift", 32'(n_sh), 32'd7);
      reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", all_outs(), 32'd0);
`ifdef BOOTH_CTRL_START_ERR_EN
      chk("async_reset_err", 32'(err), 32'd0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", all_outs(), 32'd0);
      run_op(16'($urandom), 16'($urandom), 1'b0, 1'b0);

      for (int r = 0; r < 12; r++)
         run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
